// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC core front end.
// Provides the datapath widths, the redirect kind codes, the fetch
// sequencer state encoding and the 21-bit immediate sign-extension helper.
package cpu_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned IMM21_W = 21;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'b00,
        REDIR_BR_REL = 2'b01,
        REDIR_J_REL  = 2'b10,
        REDIR_J_ABS  = 2'b11
    } redir_kind_t;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_t;

    function automatic logic [PC_W-1:0] sext21(input logic [IMM21_W-1:0] imm21);
        return {{(PC_W-IMM21_W){imm21[IMM21_W-1]}}, imm21};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation.
//   kind        in  2   redirect kind (selects pc-relative or base-relative)
//   imm21       in  21  signed byte offset
//   rel_pc      in  32  PC of the branching instruction
//   base        in  32  register operand for absolute jumps
//   target      out 32  word-aligned target address
//   misaligned  out 1   raw target had nonzero low two bits
module pc_target_calc
    import cpu_pkg::*;
(
    input  logic [1:0]         kind,
    input  logic [IMM21_W-1:0] imm21,
    input  logic [PC_W-1:0]    rel_pc,
    input  logic [PC_W-1:0]    base,
    output logic [PC_W-1:0]    target,
    output logic               misaligned
);

    logic [PC_W-1:0] raw;

    always_comb begin
        // 32-bit add wraps modulo 2^32 by construction
        if (redir_kind_t'(kind) == REDIR_J_ABS) begin
            raw = base + sext21(imm21);
        end else begin
            raw = rel_pc + sext21(imm21);
        end
        target     = {raw[PC_W-1:2], 2'b00};
        misaligned = |raw[1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches words over a req/ack
// handshake to instruction memory and hands them to decode over valid/ready.
// Branch/jump redirects from execute retarget the PC.
//   clk, rst                          clock, synchronous active-high reset
//   imem_req/imem_addr                fetch request and byte address (out)
//   imem_ack/imem_rdata               memory response strobe and word (in)
//   instr_valid/instr/instr_pc        fetched word presented to decode (out)
//   instr_ready                       decode accept (in)
//   redirect_valid/kind/imm21/pc/base redirect request from execute (in)
//   misalign                          one-cycle pulse on unaligned target (out)
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [PC_W-1:0]    imem_rdata,
    output logic               instr_valid,
    output logic [PC_W-1:0]    instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [1:0]         redirect_kind,
    input  logic [IMM21_W-1:0] redirect_imm21,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic [PC_W-1:0]    redirect_base,
    output logic               misalign
);

    fetch_state_t    state, state_n;
    logic [PC_W-1:0] pc_q, pc_n;
    logic [PC_W-1:0] addr_q, addr_n;
    logic            load_instr;
    logic            redir;
    logic [PC_W-1:0] target;
    logic            target_misaligned;

    pc_target_calc u_target (
        .kind       (redirect_kind),
        .imm21      (redirect_imm21),
        .rel_pc     (redirect_pc),
        .base       (redirect_base),
        .target     (target),
        .misaligned (target_misaligned)
    );

    assign redir = redirect_valid
                && (redir_kind_t'(redirect_kind) != REDIR_NONE)
                && (state != BOOT);

    always_comb begin
        state_n    = state;
        pc_n       = pc_q;
        load_instr = 1'b0;
        case (state)
            BOOT: begin
                state_n = FETCH;
            end
            FETCH: begin
                if (redir) begin
                    // An ack coinciding with a redirect completes the
                    // outstanding request, so no drain is needed.
                    pc_n    = target;
                    state_n = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    load_instr = 1'b1;
                    pc_n       = pc_q + PC_STEP;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (instr_ready) begin
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                if (redir) begin
                    pc_n = target;
                end
                if (imem_ack) begin
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
        // The address tracks the PC except while a stale request is
        // still outstanding; it must not move until that ack arrives.
        addr_n = (state_n == DRAIN) ? addr_q : pc_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
            misalign <= 1'b0;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            addr_q   <= addr_n;
            misalign <= redir && target_misaligned;
            if (load_instr) begin
                instr    <= imem_rdata;
                instr_pc <= pc_q;
            end
        end
    end

    assign imem_req    = (state == FETCH) || (state == DRAIN);
    assign imem_addr   = addr_q;
    assign instr_valid = (state == HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_kind = 2'b00;
    logic [20:0] redirect_imm21 = '0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] redirect_base = '0;
    logic        misalign;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .redirect_imm21 (redirect_imm21),
        .redirect_pc    (redirect_pc),
        .redirect_base  (redirect_base),
        .misalign       (misalign)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a request, checks its address stays put for
    // wait_cycles, acks it with data and checks the presented word.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data, input int unsigned wait_cycles);
        int unsigned t = 0;
        while (!imem_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("req_seen", {31'b0, imem_req}, 32'd1);
        check_eq("req_addr", imem_addr, exp_addr);
        for (int unsigned i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            check_eq("addr_stable", imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        check_eq("valid_after_ack", {31'b0, instr_valid}, 32'd1);
        check_eq("instr", instr, data);
        check_eq("instr_pc", instr_pc, exp_addr);
        check_eq("req_low_hold", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check_eq("valid_drop", {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic redirect(input logic [1:0] kind, input logic [20:0] imm,
                            input logic [31:0] rpc, input logic [31:0] base);
        redirect_valid = 1'b1;
        redirect_kind  = kind;
        redirect_imm21 = imm;
        redirect_pc    = rpc;
        redirect_base  = base;
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_kind  = 2'b00;
    endtask

    initial begin
        // 1. reset and three sequential fetches
        repeat (3) @(negedge clk);
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_misalign", {31'b0, misalign}, 32'd0);
        rst = 1'b0;
        serve(32'h0, 32'hA000_0000, 2);
        accept();
        serve(32'h4, 32'hA000_0004, 2);
        accept();
        serve(32'h8, 32'hA000_0008, 2);

        // 2. decode stalls for 5 cycles
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_valid", {31'b0, instr_valid}, 32'd1);
            check_eq("stall_instr", instr, 32'hA000_0008);
            check_eq("stall_pc", instr_pc, 32'h8);
            check_eq("stall_req", {31'b0, imem_req}, 32'd0);
        end
        accept();
        check_eq("no_pc_advance", imem_addr, 32'hC);

        // 3. backward branch from HOLD
        serve(32'hC, 32'hA000_000C, 0);
        redirect(2'b01, 21'h1FFFF0, 32'h100, 32'h0);
        check_eq("br_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("br_req", {31'b0, imem_req}, 32'd1);
        check_eq("br_addr", imem_addr, 32'h0000_00F0);
        check_eq("br_misalign", {31'b0, misalign}, 32'd0);

        // 4. jump during an outstanding fetch drains the stale word
        @(negedge clk);
        check_eq("fetch_f0", imem_addr, 32'hF0);
        redirect(2'b10, 21'h000040, 32'h200, 32'h0);
        check_eq("drain_req", {31'b0, imem_req}, 32'd1);
        check_eq("drain_addr", imem_addr, 32'hF0);
        @(negedge clk);
        check_eq("drain_addr2", imem_addr, 32'hF0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("stale_not_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("post_drain_req", {31'b0, imem_req}, 32'd1);
        check_eq("post_drain_addr", imem_addr, 32'h240);
        serve(32'h240, 32'hA000_0240, 1);

        // 5. absolute jump to a misaligned target
        redirect(2'b11, 21'h0, 32'h0, 32'h2000_0003);
        check_eq("abs_misalign", {31'b0, misalign}, 32'd1);
        check_eq("abs_addr", imem_addr, 32'h2000_0000);
        check_eq("abs_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        check_eq("misalign_once", {31'b0, misalign}, 32'd0);
        redirect(2'b00, 21'h000100, 32'h0, 32'h5000);
        check_eq("kind_none_addr", imem_addr, 32'h2000_0000);
        check_eq("kind_none_req", {31'b0, imem_req}, 32'd1);
        check_eq("kind_none_misalign", {31'b0, misalign}, 32'd0);
        serve(32'h2000_0000, 32'hA200_0000, 0);

        // 6. wrapping target, redirect together with ready in HOLD
        instr_ready = 1'b1;
        redirect(2'b01, 21'h000020, 32'hFFFF_FFF0, 32'h0);
        instr_ready = 1'b0;
        check_eq("wrap_addr", imem_addr, 32'h0000_0010);
        check_eq("wrap_valid", {31'b0, instr_valid}, 32'd0);
        redirect(2'b10, 21'h0, 32'h1000, 32'h0);
        check_eq("drain2_addr", imem_addr, 32'h10);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_drain_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_drain_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("boot_ack_ignored", {31'b0, instr_valid}, 32'd0);
        check_eq("reboot_req", {31'b0, imem_req}, 32'd1);
        check_eq("reboot_addr", imem_addr, 32'h0);
        serve(32'h0, 32'hB000_0000, 2);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
